square_shiftadd: RTL and testbench

Sequential fixed-point squarer: the inverse of the non-restoring square-root core. It takes a Q4.4 root and returns its exact Q8.8 square using a start/done handshake. It sits beside `sqrt_nonrestoring` on the same operand and result buses and is used to check root results in-system.

---
 rtl/sqrt_fixed_pkg.sv | 15 +
 rtl/sqrt_residue_check.sv | 25 ++
 rtl/square_shiftadd.sv | 125 ++++++++++++
 tb/tb_square_shiftadd.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_fixed_pkg.sv
// Shared fixed-point constants and FSM state encoding for the square-root and squarer cores.
package sqrt_fixed_pkg;

    localparam int Q_ROOT_W    = 8;
    localparam int Q_ROOT_FRAC = 4;
    localparam int Q_RAD_W     = 16;
    localparam int Q_RAD_FRAC  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sqrt_state_t;

endpackage

// File: rtl/sqrt_residue_check.sv
// Combinational residue x_ref - sq and floor-sqrt bound check (0 <= residue <= 2*Y).
module sqrt_residue_check
    import sqrt_fixed_pkg::*;
#(
    parameter int Y_W = Q_ROOT_W,
    parameter int X_W = Q_RAD_W
) (
    input  logic [X_W-1:0]        i_x_ref,
    input  logic [X_W-1:0]        i_sq,
    input  logic [Y_W-1:0]        i_y,
    output logic signed [X_W:0]   o_residue,
    output logic                  o_floor_ok
);

    logic signed [X_W:0] w_residue;
    logic [X_W-1:0]      w_two_y;

    assign w_residue = $signed({1'b0, i_x_ref}) - $signed({1'b0, i_sq});
    assign w_two_y   = {{(X_W-Y_W-1){1'b0}}, i_y, 1'b0};

    // Sign bit clear means residue >= 0, so the low bits compare as unsigned.
    assign o_residue  = w_residue;
    assign o_floor_ok = !w_residue[X_W] && (w_residue[X_W-1:0] <= w_two_y);

endmodule

// File: rtl/square_shiftadd.sv
// Sequential Q4.4 -> Q8.8 shift-add squarer with start/done handshake.
// Optional residue/floor check against x_ref is enabled by SQUARE_RESIDUE_EN.
module square_shiftadd
    import sqrt_fixed_pkg::*;
#(
    parameter int Y_W = Q_ROOT_W,
    parameter int X_W = Q_RAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [Y_W-1:0]       y_in,
`ifdef SQUARE_RESIDUE_EN
    input  logic [X_W-1:0]       x_ref,
    output logic signed [X_W:0]  residue,
    output logic                 floor_ok,
`endif
    output logic [X_W-1:0]       sq_out,
    output logic                 done,
    output logic                 busy
);

    localparam int CNT_W = $clog2(Y_W);

    sqrt_state_t      r_state;
    sqrt_state_t      w_next_state;
    logic [Y_W-1:0]   r_y;
    logic [X_W-1:0]   r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [X_W-1:0]   r_sq;
    logic             r_done;
    logic             w_last;
    logic [X_W-1:0]   w_partial;
    logic [X_W-1:0]   w_sum;

    assign w_last    = (r_cnt == CNT_W'(Y_W-1));
    assign w_partial = r_y[r_cnt] ? (X_W'(r_y) << r_cnt) : '0;
    assign w_sum     = r_acc + w_partial;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_RUN;
            ST_RUN:  if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The final partial product is folded in combinationally so sq_out lands with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sq   <= '0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_y   <= y_in;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sq   <= w_sum;
                        r_done <= 1'b1;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

`ifdef SQUARE_RESIDUE_EN
    logic [X_W-1:0]      r_x_ref;
    logic signed [X_W:0] r_residue;
    logic                r_floor_ok;
    logic signed [X_W:0] w_residue;
    logic                w_floor_ok;

    sqrt_residue_check #(
        .Y_W(Y_W),
        .X_W(X_W)
    ) u_residue_check (
        .i_x_ref    (r_x_ref),
        .i_sq       (w_sum),
        .i_y        (r_y),
        .o_residue  (w_residue),
        .o_floor_ok (w_floor_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_ref    <= '0;
            r_residue  <= '0;
            r_floor_ok <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_x_ref <= x_ref;
        end else if (r_state == ST_RUN && w_last) begin
            r_residue  <= w_residue;
            r_floor_ok <= w_floor_ok;
        end
    end

    assign residue  = r_residue;
    assign floor_ok = r_floor_ok;
`endif

    assign sq_out = r_sq;
    assign done   = r_done;
    assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_square_shiftadd.sv
// Scoreboard bench for square_shiftadd; residue checks active when SQUARE_RESIDUE_EN is defined.
module tb_square_shiftadd;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         y_in;
    logic [15:0]        x_ref;
    logic [15:0]        sq_out;
    logic               done;
    logic               busy;
`ifdef SQUARE_RESIDUE_EN
    logic signed [16:0] residue;
    logic               floor_ok;
`endif

    typedef struct {
        int sq;
        int res;
        int ok;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   cycle      = 0;
    int   compared   = 0;
    int   mismatched = 0;

    square_shiftadd #(.Y_W(8), .X_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .y_in     (y_in),
`ifdef SQUARE_RESIDUE_EN
        .x_ref    (x_ref),
        .residue  (residue),
        .floor_ok (floor_ok),
`endif
        .sq_out   (sq_out),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cycle);
        end
    endtask

    // Scoreboard monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("sq_out", int'(sq_out), e.sq);
                checkOutput("done_cycle", cycle, e.cyc);
`ifdef SQUARE_RESIDUE_EN
                checkOutput("residue", int'(residue), e.res);
                checkOutput("floor_ok", int'(floor_ok), e.ok);
`endif
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic applyStimulus(input logic [7:0] y, input logic [15:0] xref,
                                 input int expSq, input int expRes, input int expOk);
        exp_t e;
        waitIdle();
        start = 1'b1;
        y_in  = y;
        x_ref = xref;
        e.sq  = expSq;
        e.res = expRes;
        e.ok  = expOk;
        e.cyc = cycle + 1 + 8;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        y_in  = ~y;
        x_ref = ~xref;
    endtask

    function automatic int isqrt(input int x);
        for (int r = 255; r >= 0; r--)
            if (r * r <= x) return r;
        return 0;
    endfunction

    initial begin
        int   k;
        exp_t e;
        int   y;
        int   n;

        rst   = 1'b1;
        start = 1'b0;
        y_in  = '0;
        x_ref = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_sq_out", int'(sq_out), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_busy", int'(busy), 0);
`ifdef SQUARE_RESIDUE_EN
        checkOutput("reset_residue", int'(residue), 0);
        checkOutput("reset_floor_ok", int'(floor_ok), 0);
`endif
        rst = 1'b0;

        applyStimulus(8'h10, 16'h0100, 16'h0100, 0, 1);
        applyStimulus(8'h40, 16'h1000, 16'h1000, 0, 1);
        applyStimulus(8'hFF, 16'hFE01, 16'hFE01, 0, 1);
        applyStimulus(8'h00, 16'h0000, 16'h0000, 0, 1);
        applyStimulus(8'h16, 16'h0200, 484, 28, 1);
        applyStimulus(8'h17, 16'h0200, 529, -17, 0);
        applyStimulus(8'h15, 16'h0200, 441, 71, 0);

        // Stray starts at accept+3 and accept+8 must be dropped.
        waitIdle();
        start = 1'b1;
        y_in  = 8'h33;
        x_ref = 16'h0A29;
        k     = cycle + 1;
        e.sq = 16'h0A29; e.res = 0; e.ok = 1; e.cyc = k + 8;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_at_k8", int'(busy), 1);
        @(negedge clk);
        checkOutput("busy_at_k9", int'(busy), 0);
        start = 1'b1;
        y_in  = 8'h20;
        x_ref = 16'h0400;
        e.sq = 16'h0400; e.res = 0; e.ok = 1; e.cyc = k + 18;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;

        // Reset during RUN aborts with no done.
        waitIdle();
        start = 1'b1;
        y_in  = 8'h55;
        x_ref = 16'h1C39;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_sq_out", int'(sq_out), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        applyStimulus(8'h0C, 16'h0090, 16'h0090, 0, 1);

        // Closed loop: floor root of each X squares back within the bound.
        for (int x = 0; x <= 16'hFFFF; x += 16'h0101) begin
            y = isqrt(x);
            applyStimulus(8'(y), 16'(x), y * y, x - y * y, 1);
        end

        n = 0;
        while ((sbq.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("pending_expectations", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
